// File: rtl/rob_ctrl.sv
// rob_ctrl: reorder-buffer control that allocates ids, records completions and exceptions,
// and retires entries strictly in program order at most one per cycle.
module rob_ctrl #(
   parameter int ROB_DEPTH = 16,
   parameter int ROB = $clog2(ROB_DEPTH)
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           dec_e_,
   output logic [ROB-1:0] dec_rob_id,
   output logic           rob_full,
   input  logic           wb_e_,
   input  logic [ROB-1:0] wb_rob_id,
   input  logic           wb_exp,
   input  logic           flush,
   output logic           commit_e_,
   output logic [ROB-1:0] commit_rob_id,
   output logic           commit_exp,
   output logic           busy
);
   logic [ROB_DEPTH-1:0] valid_q, valid_d, done_q, done_d, exp_q, exp_d;
   logic [ROB-1:0] head_q, head_d, tail_q, tail_d, cid_q, cid_d;
   logic [ROB:0] count_q, count_d;
   logic ce_q, ce_d, cexp_q, cexp_d;
   logic alloc, wb_ok, commit;
   assign rob_full = count_q == ROB_DEPTH[ROB:0];
   assign busy = count_q != '0;
   assign dec_rob_id = tail_q;
   assign commit_e_ = ce_q;
   assign commit_rob_id = cid_q;
   assign commit_exp = cexp_q;
   always_comb begin
      alloc = !dec_e_ && !rob_full;
      wb_ok = !wb_e_ && valid_q[wb_rob_id];
      commit = valid_q[head_q] && done_q[head_q];
      valid_d = valid_q;
      done_d = done_q;
      exp_d = exp_q;
      if (wb_ok) begin
         done_d[wb_rob_id] = 1'b1;
         exp_d[wb_rob_id] = wb_exp;
      end
      if (commit) valid_d[head_q] = 1'b0;
      // the tail entry is invalid whenever alloc is possible, so it never collides with wb or commit
      if (alloc) begin
         valid_d[tail_q] = 1'b1;
         done_d[tail_q] = 1'b0;
         exp_d[tail_q] = 1'b0;
      end
      head_d = commit ? head_q + 1'b1 : head_q;
      tail_d = alloc ? tail_q + 1'b1 : tail_q;
      count_d = count_q + (ROB+1)'(alloc) - (ROB+1)'(commit);
      ce_d = !commit;
      cid_d = commit ? head_q : cid_q;
      cexp_d = commit ? exp_q[head_q] : cexp_q;
      if (flush) begin
         valid_d = '0;
         head_d = '0;
         tail_d = '0;
         count_d = '0;
         ce_d = 1'b1;
      end
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid_q <= '0;
         done_q <= '0;
         exp_q <= '0;
         head_q <= '0;
         tail_q <= '0;
         count_q <= '0;
         ce_q <= 1'b1;
         cid_q <= '0;
         cexp_q <= 1'b0;
      end else begin
         valid_q <= valid_d;
         done_q <= done_d;
         exp_q <= exp_d;
         head_q <= head_d;
         tail_q <= tail_d;
         count_q <= count_d;
         ce_q <= ce_d;
         cid_q <= cid_d;
         cexp_q <= cexp_d;
      end
   end
endmodule

// File: tb/tb_rob_ctrl.sv
// tb_rob_ctrl: vector table plus commit scoreboard for rob_ctrl.
module tb_rob_ctrl;
   logic clk = 1'b0, reset = 1'b1;
   logic dec_e_ = 1'b1, wb_e_ = 1'b1, wb_exp = 1'b0, flush = 1'b0;
   logic [3:0] wb_rob_id = '0;
   logic [3:0] dec_rob_id, commit_rob_id;
   logic rob_full, commit_e_, commit_exp, busy;
   logic ovf_ok = 1'b0;
   int errors = 0, checks = 0;
   typedef struct packed {logic [3:0] id; logic x;} sb_t;
   sb_t q[$];
   typedef struct packed {
      logic d_n, w_n; logic [3:0] wid; logic wx, fl;
      logic [3:0] e_dec; logic e_full, e_busy, e_ce; logic [3:0] e_cid;
   } vec_t;
   vec_t tbl [0:8];
   rob_ctrl dut (
      .clk(clk), .reset(reset), .dec_e_(dec_e_), .dec_rob_id(dec_rob_id), .rob_full(rob_full),
      .wb_e_(wb_e_), .wb_rob_id(wb_rob_id), .wb_exp(wb_exp), .flush(flush),
      .commit_e_(commit_e_), .commit_rob_id(commit_rob_id), .commit_exp(commit_exp), .busy(busy)
   );
   always #5 clk = ~clk;
   task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
      end
   endtask
   task automatic cyc(input logic d, input logic w, input logic [3:0] id, input logic x, input logic f);
      dec_e_ = d; wb_e_ = w; wb_rob_id = id; wb_exp = x; flush = f;
      @(posedge clk);
      #1;
   endtask
   task automatic idle();
      cyc(1'b1, 1'b1, 4'd0, 1'b0, 1'b0);
   endtask
   task automatic push(input logic [3:0] id, input logic x);
      q.push_back({id, x});
   endtask
   task automatic drain();
      for (int i = 0; i < 40 && q.size() != 0; i++) idle();
      idle();
      chk("drain_empty", q.size(), 0);
   endtask
   always @(negedge clk) begin
      if (!reset) begin
         checks++;
         if (!dec_e_ && rob_full && !ovf_ok) begin
            errors++;
            $display("FAIL alloc_when_full: dec_e_=0 while rob_full=1 at %0t", $time);
         end
         if (!commit_e_) begin
            if (q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_commit: id %0d exp %0b, expected none", commit_rob_id, commit_exp);
            end else begin
               sb_t s;
               s = q.pop_front();
               chk("commit_id", commit_rob_id, s.id);
               chk("commit_exp", commit_exp, s.x);
            end
         end
      end
   end
   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end
   initial begin
      tbl[0] = '{1'b0, 1'b1, 4'd0, 1'b0, 1'b0, 4'd1, 1'b0, 1'b1, 1'b1, 4'd0};
      tbl[1] = '{1'b0, 1'b1, 4'd0, 1'b0, 1'b0, 4'd2, 1'b0, 1'b1, 1'b1, 4'd0};
      tbl[2] = '{1'b0, 1'b1, 4'd0, 1'b0, 1'b0, 4'd3, 1'b0, 1'b1, 1'b1, 4'd0};
      tbl[3] = '{1'b1, 1'b0, 4'd2, 1'b0, 1'b0, 4'd3, 1'b0, 1'b1, 1'b1, 4'd0};
      tbl[4] = '{1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 4'd3, 1'b0, 1'b1, 1'b1, 4'd0};
      tbl[5] = '{1'b1, 1'b0, 4'd1, 1'b0, 1'b0, 4'd3, 1'b0, 1'b1, 1'b0, 4'd0};
      tbl[6] = '{1'b1, 1'b1, 4'd0, 1'b0, 1'b0, 4'd3, 1'b0, 1'b1, 1'b0, 4'd1};
      tbl[7] = '{1'b1, 1'b1, 4'd0, 1'b0, 1'b0, 4'd3, 1'b0, 1'b0, 1'b0, 4'd2};
      tbl[8] = '{1'b1, 1'b1, 4'd0, 1'b0, 1'b0, 4'd3, 1'b0, 1'b0, 1'b1, 4'd2};
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("rst_ce", commit_e_, 1);
      chk("rst_cid", commit_rob_id, 0);
      chk("rst_cexp", commit_exp, 0);
      chk("rst_dec", dec_rob_id, 0);
      chk("rst_full", rob_full, 0);
      chk("rst_busy", busy, 0);
      for (int i = 0; i < 3; i++) push(i[3:0], 1'b0);
      for (int i = 0; i < 9; i++) begin
         cyc(tbl[i].d_n, tbl[i].w_n, tbl[i].wid, tbl[i].wx, tbl[i].fl);
         chk("tbl_dec", dec_rob_id, tbl[i].e_dec);
         chk("tbl_full", rob_full, tbl[i].e_full);
         chk("tbl_busy", busy, tbl[i].e_busy);
         chk("tbl_ce", commit_e_, tbl[i].e_ce);
         chk("tbl_cid", commit_rob_id, tbl[i].e_cid);
      end
      cyc(1'b1, 1'b1, 4'd0, 1'b0, 1'b1);
      chk("flush_dec", dec_rob_id, 0);
      for (int i = 0; i < 16; i++) begin
         push(i[3:0], 1'b0);
         cyc(1'b0, 1'b1, 4'd0, 1'b0, 1'b0);
      end
      chk("fill_full", rob_full, 1);
      chk("fill_busy", busy, 1);
      chk("fill_dec", dec_rob_id, 0);
      cyc(1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
      chk("full_hold", rob_full, 1);
      ovf_ok = 1'b1;
      cyc(1'b0, 1'b1, 4'd0, 1'b0, 1'b0);
      ovf_ok = 1'b0;
      chk("refused_full", rob_full, 0);
      chk("refused_dec", dec_rob_id, 0);
      chk("refused_ce", commit_e_, 0);
      push(4'd0, 1'b0);
      cyc(1'b0, 1'b1, 4'd0, 1'b0, 1'b0);
      chk("wrap_full", rob_full, 1);
      chk("wrap_dec", dec_rob_id, 1);
      for (int i = 1; i <= 16; i++) cyc(1'b1, 1'b0, i[3:0], 1'b0, 1'b0);
      drain();
      chk("fill_end_busy", busy, 0);
      cyc(1'b1, 1'b1, 4'd0, 1'b0, 1'b1);
      for (int i = 0; i <= 40; i++) begin
         if (i < 40) push(i[3:0], 1'b0);
         cyc(i < 40 ? 1'b0 : 1'b1, i > 0 ? 1'b0 : 1'b1, 4'(i - 1), 1'b0, 1'b0);
      end
      drain();
      chk("stream_busy", busy, 0);
      chk("stream_dec", dec_rob_id, 8);
      cyc(1'b1, 1'b1, 4'd0, 1'b0, 1'b1);
      repeat (3) cyc(1'b0, 1'b1, 4'd0, 1'b0, 1'b0);
      push(4'd0, 1'b0);
      push(4'd1, 1'b1);
      cyc(1'b1, 1'b0, 4'd1, 1'b1, 1'b0);
      cyc(1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
      chk("exp_ce_pre", commit_e_, 1);
      idle();
      chk("exp_c0_id", commit_rob_id, 0);
      chk("exp_c0_exp", commit_exp, 0);
      idle();
      chk("exp_c1_id", commit_rob_id, 1);
      chk("exp_c1_exp", commit_exp, 1);
      chk("exp_busy", busy, 1);
      cyc(1'b1, 1'b1, 4'd0, 1'b0, 1'b1);
      chk("exp_flush_busy", busy, 0);
      chk("exp_flush_dec", dec_rob_id, 0);
      chk("exp_flush_ce", commit_e_, 1);
      repeat (3) cyc(1'b0, 1'b1, 4'd0, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 4'd5, 1'b1, 1'b0);
      repeat (3) idle();
      chk("bad_wb_busy", busy, 1);
      chk("bad_wb_dec", dec_rob_id, 3);
      chk("bad_wb_ce", commit_e_, 1);
      for (int i = 0; i < 3; i++) push(i[3:0], 1'b0);
      for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, i[3:0], 1'b0, 1'b0);
      drain();
      repeat (3) cyc(1'b0, 1'b1, 4'd0, 1'b0, 1'b0);
      push(4'd3, 1'b0);
      push(4'd4, 1'b0);
      cyc(1'b1, 1'b0, 4'd3, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 4'd4, 1'b0, 1'b0);
      drain();
      chk("id5_pending_busy", busy, 1);
      chk("id5_ce", commit_e_, 1);
      cyc(1'b1, 1'b1, 4'd0, 1'b0, 1'b1);
      repeat (4) cyc(1'b0, 1'b1, 4'd0, 1'b0, 1'b0);
      push(4'd0, 1'b0);
      push(4'd1, 1'b1);
      cyc(1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 4'd1, 1'b1, 1'b0);
      repeat (6) cyc(1'b0, 1'b1, 4'd0, 1'b0, 1'b0);
      chk("mid_cid", commit_rob_id, 1);
      chk("mid_cexp", commit_exp, 1);
      chk("mid_dec", dec_rob_id, 10);
      dec_e_ = 1'b1;
      @(negedge clk);
      #2;
      reset = 1'b1;
      #1;
      chk("arst_ce", commit_e_, 1);
      chk("arst_cid", commit_rob_id, 0);
      chk("arst_cexp", commit_exp, 0);
      chk("arst_dec", dec_rob_id, 0);
      chk("arst_full", rob_full, 0);
      chk("arst_busy", busy, 0);
      q.delete();
      @(negedge clk);
      reset = 1'b0;
      cyc(1'b0, 1'b1, 4'd0, 1'b0, 1'b0);
      chk("post_rst_dec", dec_rob_id, 1);
      chk("post_rst_busy", busy, 1);
      idle();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/rob_ctrl.md
# rob_ctrl

In-order completion tracker (reorder-buffer control) for the out-of-order core. It allocates ROB ids to decoded instructions, records writeback completion and exception status per entry, and retires entries strictly in program order. Each retirement is emitted on the commit_e_/commit_rob_id interface that the scheduler consumes. It sits between decode/rename (allocation), the execution units (writeback) and the scheduler (commit).

## Interface
- ROB_DEPTH, default `RobDepth (16): number of entries, power of two, at least 4
- ROB, default $clog2(ROB_DEPTH): id width (derived, do not override)

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- dec_e_  in  1  active-low allocate request from decode
- dec_rob_id  out  ROB  id granted to the current request (tail pointer)
- rob_full  out  1  no free entry; decode must stall
- wb_e_  in  1  active-low writeback/completion strobe
- wb_rob_id  in  ROB  entry being completed
- wb_exp  in  1  completing instruction raised an exception
- flush  in  1  active-high synchronous pipeline flush
- commit_e_  out  1  active-low commit strobe (registered)
- commit_rob_id  out  ROB  id being committed (registered)
- commit_exp  out  1  committed entry carries an exception (registered)
- busy  out  1  at least one entry is allocated

## Operation
- Storage per entry: valid, done, exp. Pointers: head, tail (ROB bits, wrap modulo ROB_DEPTH). Occupancy: count (ROB+1 bits, 0..ROB_DEPTH).
- Allocate: when dec_e_=0 and rob_full=0, set entry[tail] to valid=1, done=0, exp=0, then increment tail. When dec_e_=0 and rob_full=1, drop the request with no state change. This is a protocol violation and the bench asserts it never occurs.
- Writeback: when wb_e_=0 and entry[wb_rob_id].valid=1, set done=1 and exp=wb_exp. A writeback to an invalid entry is ignored.
- Commit: when entry[head].valid and entry[head].done, clear entry[head].valid, increment head, and register commit_e_=0, commit_rob_id=head (old value), commit_exp=entry[head].exp. Otherwise register commit_e_=1.
- At most one commit per cycle.
- commit_rob_id and commit_exp hold their last value while commit_e_=1.
- Exceptions are only reported. The owner of flush (the CPU top) reacts to commit_exp=1 by asserting flush.
- Count update per cycle: +1 on allocate, -1 on commit. Allocate and commit in the same cycle leave the count unchanged.
- Full condition: rob_full = (count == ROB_DEPTH). Because commit frees its entry only at the clock edge, an allocate in a full cycle is refused even when a commit happens in that same cycle.
- Flush has priority over allocate, writeback and commit in the same cycle:
  - clear every valid bit
  - set head = tail = 0 and count = 0
  - register commit_e_=1
- Writeback and allocation on the same entry in one cycle cannot occur, because the entry is invalid at allocation time. The writeback is ignored.

## Timing
- Reset values (asynchronous):
  - commit_e_=1, commit_rob_id=0, commit_exp=0
  - all valid/done/exp = 0
  - head=tail=0, count=0
  - hence dec_rob_id=0, rob_full=0, busy=0
- dec_rob_id, rob_full and busy are combinational from registered state. They are valid in the same cycle as dec_e_.
- Writeback sampled at edge k sets done. If that entry is head, commit_e_ goes low after edge k+1, so writeback to commit_e_ latency is 2 cycles.
- Steady state: back-to-back commits at 1 per cycle when consecutive head entries are done.
- Wrap-around: head and tail roll from ROB_DEPTH-1 to 0 with no bubble.
- After flush at edge k:
  - commit_e_=1 from edge k
  - the first allocation after the flush receives id 0 in cycle k+1

## Test plan
- Reset, then allocate 3 (ids 0,1,2), writeback order 2,0,1 -> commits ids 0,1,2 on consecutive cycles, with commit 0 exactly 2 cycles after wb of id 0.
- Fill 16 entries -> rob_full=1, busy=1. Then allocate and commit in the same cycle -> allocation refused, count becomes 15. On the next cycle allocation succeeds with id 0 after wrap.
- Continuous allocate/writeback/commit for 40 instructions -> commit_rob_id sequence 0..15,0..15,0..7 with no gaps or duplicates.
- Writeback id 1 with wb_exp=1, then id 0 -> commit id 0 with exp=0, then id 1 with exp=1. Assert flush the next cycle -> busy=0 and dec_rob_id=0.
- Writeback to an unallocated id 5 while entries 0..2 are in flight -> no commit of 5, no state change.
- Assert reset mid-stream with 8 entries in flight -> all outputs return to their reset values immediately, without waiting for clk.
